// File: rtl/lfsr_misr_pkg.sv
// lfsr_misr_pkg: shared FSM states, LFSR taps, MISR polynomial and LFSR step for the harness
package lfsr_misr_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, FLUSH, DONE} state_t;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [7:0] NONZERO_SEED = 8'h01;
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/misr16.sv
// misr16: 16-bit MISR x^16+x^12+x^5+1 (clk, clear, init, enable, data_in[7:0] -> sig[15:0])
module misr16
  import lfsr_misr_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic        init,
  input  logic        enable,
  input  logic [7:0]  data_in,
  output logic [15:0] sig
);
  always_ff @(posedge clk)
    if (clear || init) sig <= '0;
    else if (enable) sig <= {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ {8'h00, data_in};
endmodule

// File: rtl/lfsr_misr_harness.sv
// lfsr_misr_harness: LFSR stimulus into a CUT and MISR signature of its response (clk, clear, start, seed, cct_output -> cct_input, busy, done, signature)
module lfsr_misr_harness
  import lfsr_misr_pkg::*;
#(
  parameter int unsigned PATTERN_COUNT = 256,
  parameter int unsigned CUT_LATENCY   = 0
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        start,
  input  logic [7:0]  seed,
  output logic [7:0]  cct_input,
  input  logic [7:0]  cct_output,
  output logic        busy,
  output logic        done,
  output logic [15:0] signature
);
  localparam int unsigned LW = CUT_LATENCY > 0 ? CUT_LATENCY : 1;
  state_t r_state, w_next;
  logic [7:0] r_lfsr, r_seed;
  logic [15:0] r_cnt;
  logic [LW-1:0] r_vld, w_vld_nxt;
  logic w_vld_in, w_capture, w_last, w_accept, w_init;
  assign w_accept = start && (r_state == IDLE || r_state == DONE);
  assign w_last = r_cnt == 16'(PATTERN_COUNT - 1);
  assign w_vld_in = r_state == RUN;
  assign w_capture = CUT_LATENCY == 0 ? w_vld_in : r_vld[LW-1];
  assign w_init = r_state == LOAD;
  if (LW == 1) begin : g_v1
    assign w_vld_nxt = w_vld_in;
  end else begin : g_vn
    assign w_vld_nxt = {r_vld[LW-2:0], w_vld_in};
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? LOAD : IDLE;
      LOAD:    w_next = RUN;
      RUN:     w_next = w_last ? (CUT_LATENCY == 0 ? DONE : FLUSH) : RUN;
      FLUSH:   w_next = ~|w_vld_nxt ? DONE : FLUSH;
      DONE:    w_next = start ? LOAD : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) r_state <= clear ? IDLE : w_next;
  always_ff @(posedge clk)
    if (clear) begin
      r_lfsr <= '0;
      r_seed <= '0;
      r_cnt  <= '0;
      r_vld  <= '0;
    end else begin
      if (w_accept) r_seed <= seed;
      if (r_state == LOAD) begin
        r_lfsr <= r_seed == 8'h00 ? NONZERO_SEED : r_seed;
        r_cnt  <= '0;
        r_vld  <= '0;
      end else if (r_state == RUN || r_state == FLUSH) begin
        r_lfsr <= lfsr_step(r_lfsr);
        r_cnt  <= r_cnt + 16'(w_vld_in);
        r_vld  <= w_vld_nxt;
      end
    end
  misr16 u_misr (
    .clk(clk),
    .clear(clear),
    .init(w_init),
    .enable(w_capture),
    .data_in(cct_output),
    .sig(signature)
  );
  assign cct_input = r_lfsr;
  assign busy = r_state == LOAD || r_state == RUN || r_state == FLUSH;
  assign done = r_state == DONE;
endmodule

// File: tb/tb_lfsr_misr_harness.sv
// tb_lfsr_misr_harness: randomized multi-instance bench with a cycle-count reference model
module tb_lfsr_misr_harness;
  localparam int NI = 5;
  localparam int MAXP = 264;
  localparam logic [7:0] LC [3] = '{8'hAA, 8'h55, 8'hAB};
  localparam logic [15:0] LS [3] = '{16'h00AA, 16'h0101, 16'h02A9};
  function automatic int pc_of(int i);
    return i == 2 ? 256 : i == 3 ? 1 : i == 4 ? 20 : 3;
  endfunction
  function automatic int lat_of(int i);
    return i == 1 ? 1 : i == 4 ? 3 : 0;
  endfunction
  function automatic logic [7:0] cut_f(int m, logic [7:0] k, logic [7:0] x);
    return m == 0 ? x : m == 1 ? 8'h00 : (x ^ k) + {x[3:0], x[7:4]};
  endfunction
  function automatic logic [7:0] lstep(logic [7:0] v);
    int ones;
    ones = $countones(v & 8'b1011_1000);
    return {v[6:0], 1'b0} | 8'(ones % 2);
  endfunction
  function automatic logic [15:0] mstep(logic [15:0] s, logic [7:0] d);
    logic [16:0] t;
    t = {s, 1'b0};
    if (t[16]) t = t ^ 17'h11021;
    return t[15:0] ^ {8'h00, d};
  endfunction
  logic clk = 0;
  logic clear [NI];
  logic start [NI];
  logic busy [NI];
  logic done [NI];
  logic [7:0] seed [NI];
  logic [7:0] cin [NI];
  logic [7:0] cout [NI];
  logic [15:0] sig [NI];
  int mode [NI];
  logic [7:0] key [NI];
  int checks = 0, errors = 0;
  int mt [NI] = '{default: -1};
  int bc [NI] = '{default: 0};
  logic [7:0] m_seed [NI];
  int m_mode [NI];
  logic [7:0] pat [NI][MAXP];
  logic [15:0] sgs [NI][257];
  logic [7:0] hold_c [NI];
  logic [15:0] hold_s [NI];
  bit armed = 0, tmo_any = 0, tmo_seen = 0;
  always #5 clk = ~clk;
  for (genvar i = 0; i < NI; i++) begin : g_dut
    localparam int LI = lat_of(i);
    localparam int DI = LI == 0 ? 0 : LI - 1;
    logic [7:0] dl [3];
    always @(posedge clk) begin
      dl[0] <= cin[i];
      dl[1] <= dl[0];
      dl[2] <= dl[1];
    end
    assign cout[i] = cut_f(mode[i], key[i], LI == 0 ? cin[i] : dl[DI]);
    lfsr_misr_harness #(.PATTERN_COUNT(pc_of(i)), .CUT_LATENCY(lat_of(i))) u_dut (
      .clk(clk),
      .clear(clear[i]),
      .start(start[i]),
      .seed(seed[i]),
      .cct_input(cin[i]),
      .cct_output(cout[i]),
      .busy(busy[i]),
      .done(done[i]),
      .signature(sig[i])
    );
  end
  // mt = edges since the accepted start edge (0 = LOAD), -1 = idle after clear, capped at done
  function automatic logic [7:0] e_cin(int g);
    if (mt[g] < 0) return 8'h00;
    if (mt[g] == 0) return hold_c[g];
    return pat[g][mt[g]-1];
  endfunction
  function automatic logic [15:0] e_sig(int g);
    int a;
    if (mt[g] < 0) return 16'h0000;
    if (mt[g] == 0) return hold_s[g];
    a = mt[g] - 1 - lat_of(g);
    a = a < 0 ? 0 : a > pc_of(g) ? pc_of(g) : a;
    return sgs[g][a];
  endfunction
  function automatic logic e_busy(int g);
    return mt[g] >= 0 && mt[g] <= pc_of(g) + lat_of(g);
  endfunction
  function automatic logic e_done(int g);
    return mt[g] == pc_of(g) + lat_of(g) + 1;
  endfunction
  initial forever begin
    @(posedge clk);
    for (int g = 0; g < NI; g++) begin
      int n, l;
      logic [7:0] p;
      logic [15:0] s;
      n = pc_of(g);
      l = lat_of(g);
      if (clear[g]) mt[g] = -1;
      else if (start[g] && (mt[g] == -1 || mt[g] == n + l + 1)) begin
        hold_c[g] = e_cin(g);
        hold_s[g] = e_sig(g);
        m_seed[g] = seed[g];
        m_mode[g] = mode[g];
        p = seed[g] == 8'h00 ? 8'h01 : seed[g];
        s = 16'h0000;
        for (int k = 0; k < MAXP; k++) begin
          pat[g][k] = p;
          if (k <= n) sgs[g][k] = s;
          if (k < n) s = mstep(s, cut_f(mode[g], key[g], p));
          p = lstep(p);
        end
        mt[g] = 0;
      end else if (mt[g] >= 0 && mt[g] < n + l + 1) mt[g] = mt[g] + 1;
    end
  end
  task automatic chk(string nm, int g, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] t=%0d got %h expected %h", nm, g, mt[g], got, exp);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (armed) begin
      if (tmo_any && !tmo_seen) begin
        tmo_seen = 1;
        errors++;
      end
      for (int g = 0; g < NI; g++) begin
        chk("cct_input", g, cin[g], e_cin(g));
        chk("signature", g, sig[g], e_sig(g));
        chk("busy", g, busy[g], e_busy(g));
        chk("done", g, done[g], e_done(g));
        bc[g] = mt[g] == 0 ? int'(busy[g]) : bc[g] + int'(busy[g]);
      end
      if (m_seed[0] === 8'hAA && m_mode[0] == 0 && mt[0] >= 1 && mt[0] <= 4) begin
        if (mt[0] <= 3) chk("lit_cin", 0, cin[0], LC[mt[0]-1]);
        if (mt[0] >= 2) chk("lit_sig", 0, sig[0], LS[mt[0]-2]);
        if (mt[0] == 3) chk("lit_done_early", 0, done[0], 0);
        if (mt[0] == 4) chk("lit_done", 0, done[0], 1);
      end
      if (m_seed[1] === 8'hAA && m_mode[1] == 0) begin
        if (mt[1] == 4) chk("lit_done_early_l1", 1, done[1], 0);
        if (mt[1] == 5) chk("lit_sig_l1", 1, sig[1], 16'h02A9);
        if (mt[1] == 5) chk("lit_done_l1", 1, done[1], 1);
      end
      if (m_seed[3] === 8'h00 && m_mode[3] == 0) begin
        if (mt[3] == 1) chk("lit_seed0_cin", 3, cin[3], 8'h01);
        if (mt[3] == 2) chk("lit_seed0_sig", 3, sig[3], 16'h0001);
      end
      if (m_mode[2] == 1 && mt[2] == 257) begin
        chk("lit_zero_sig", 2, sig[2], 16'h0000);
        chk("lit_busy_cycles", 2, bc[2], 257);
      end
    end
  end
  task automatic wait_done(int g);
    for (int c = 0; c < 400 && done[g] !== 1'b1; c++) @(negedge clk);
    if (done[g] !== 1'b1) begin
      tmo_any = 1;
      $display("FAIL timeout[%0d] done=%b required 1 within 400 cycles", g, done[g]);
    end
  endtask
  task automatic run(int g, logic [7:0] s, int m, logic [7:0] k, bit hold);
    mode[g] = m;
    key[g] = k;
    seed[g] = s;
    start[g] = 1;
    @(negedge clk);
    seed[g] = 8'($urandom);
    if (!hold) start[g] = 0;
    wait_done(g);
    start[g] = 0;
    @(negedge clk);
  endtask
  task automatic clear_mid(int g, logic [7:0] s, int m, int cyc);
    mode[g] = m;
    seed[g] = s;
    start[g] = 1;
    @(negedge clk);
    start[g] = 0;
    repeat (cyc) @(negedge clk);
    clear[g] = 1;
    @(negedge clk);
    clear[g] = 0;
    repeat (2) @(negedge clk);
  endtask
  initial begin
    for (int g = 0; g < NI; g++) begin
      clear[g] = 1;
      start[g] = 0;
      seed[g] = 8'h00;
      mode[g] = 0;
      key[g] = 8'h00;
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < NI; g++) clear[g] = 0;
    armed = 1;
    run(0, 8'hAA, 0, 8'h00, 0);
    run(1, 8'hAA, 0, 8'h00, 0);
    run(3, 8'h00, 0, 8'h00, 0);
    run(2, 8'hAA, 1, 8'h00, 0);
    run(2, 8'hAA, 0, 8'h00, 1);
    run(2, 8'hAA, 0, 8'h00, 0);
    clear_mid(2, 8'hAA, 0, 100);
    run(2, 8'hAA, 0, 8'h00, 0);
    run(0, 8'hAA, 0, 8'h00, 0);
    clear[0] = 1;
    start[0] = 1;
    @(negedge clk);
    clear[0] = 0;
    start[0] = 0;
    repeat (3) @(negedge clk);
    run(0, 8'hAA, 0, 8'h00, 0);
    run(1, 8'h00, 2, 8'h5C, 1);
    repeat (6) run(0, 8'($urandom), $urandom_range(0, 2), 8'($urandom), 1'($urandom_range(0, 1)));
    repeat (12) begin
      logic [7:0] s;
      s = $urandom_range(0, 3) == 0 ? 8'h00 : 8'($urandom);
      run(4, s, $urandom_range(0, 2), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    clear_mid(4, 8'($urandom), 2, $urandom_range(1, 20));
    run(4, 8'h3C, 2, 8'hA5, 0);
    run(3, 8'($urandom), 2, 8'($urandom), 0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
